// File: rtl/mdu_unit_if.sv
// Issue/read bundle between the EX-stage pipeline and the multiply/divide unit.
// The pipeline side is the master; the unit is the slave.
interface mdu_unit_if;
  logic        start;
  logic        cancel;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hi;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output start, cancel, op, a, b, rd_hi,
    input  busy, hi, lo, rd_data
  );

  modport slave (
    input  start, cancel, op, a, b, rd_hi,
    output busy, hi, lo, rd_data
  );
endinterface

// File: rtl/mdu_unit.sv
// MIPS HI/LO multiply/divide unit: MULT*/DIV* commit MULT_CYCLES/DIV_CYCLES edges after issue, MTHI/MTLO in 1.
// No internal queueing: a start seen while busy is dropped, so hazard control must stall on busy.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       rst_n,
  mdu_unit_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {IDLE, BUSY} state_e;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  op_e         op;
  state_e      state;
  logic [CW-1:0] cnt;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] res_hi, res_lo;
  logic        res_en;
  logic        accept;

  assign op     = op_e'(bus.op);
  assign accept = bus.start & ~bus.cancel & ~busy_q & (op != OP_NONE) & (op != OP_RSVD);

  // One 64x64 multiplier serves both flavours; the operands' upper halves pick signedness.
  logic        mul_sx;
  logic [63:0] mul_a, mul_b, prod;

  assign mul_sx = (op == OP_MULT);
  assign mul_a  = {{32{mul_sx & bus.a[31]}}, bus.a};
  assign mul_b  = {{32{mul_sx & bus.b[31]}}, bus.b};
  assign prod   = mul_a * mul_b;

  // Signed divide runs on magnitudes; -2^31 / -1 falls out as 0x80000000 rem 0 without a special case.
  logic        div_sx, neg_a, neg_b;
  logic [31:0] mag_a, mag_b, quo, rem, quo_f, rem_f;

  assign div_sx = (op == OP_DIV);
  assign neg_a  = div_sx & bus.a[31];
  assign neg_b  = div_sx & bus.b[31];
  assign mag_a  = neg_a ? -bus.a : bus.a;
  assign mag_b  = (bus.b == 32'd0) ? 32'd1 : (neg_b ? -bus.b : bus.b);
  assign quo    = mag_a / mag_b;
  assign rem    = mag_a % mag_b;
  assign quo_f  = (neg_a ^ neg_b) ? -quo : quo;
  assign rem_f  = neg_a ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                res_hi <= prod[63:32];
                res_lo <= prod[31:0];
                res_en <= 1'b1;
                cnt    <= CW'(MULT_CYCLES);
                state  <= BUSY;
                busy_q <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                res_hi <= rem_f;
                res_lo <= quo_f;
                res_en <= (bus.b != 32'd0);
                cnt    <= CW'(DIV_CYCLES);
                state  <= BUSY;
                busy_q <= 1'b1;
              end
              OP_MTHI: hi_q <= bus.a;
              OP_MTLO: lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (res_en) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.rd_data = bus.rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed plus randomized bench for mdu_unit against a plain-arithmetic HI/LO model.
module tb_mdu_unit;
  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;
  logic [31:0] mhi, mlo;

  mdu_unit_if bus ();

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour in 64-bit integer arithmetic.
  task automatic model_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int               xi, yi;
    longint           p, q, r;
    longint unsigned  pu, qu, ru;
    xi = x;
    yi = y;
    case (o)
      3'd1: begin p = longint'(xi) * longint'(yi); mhi = p[63:32]; mlo = p[31:0]; end
      3'd2: begin
        pu = longint'({32'd0, x}) * longint'({32'd0, y});
        mhi = pu[63:32]; mlo = pu[31:0];
      end
      3'd3: if (y != 0) begin
        q = longint'(xi) / longint'(yi);
        r = longint'(xi) % longint'(yi);
        mlo = q[31:0]; mhi = r[31:0];
      end
      3'd4: if (y != 0) begin
        qu = {32'd0, x} / {32'd0, y};
        ru = {32'd0, x} % {32'd0, y};
        mlo = qu[31:0]; mhi = ru[31:0];
      end
      3'd5: mhi = x;
      3'd6: mlo = x;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit cxl, input bit poke);
    int          n, expn;
    bit          acc;
    logic [31:0] old_hi, old_lo;
    acc    = !cxl && (o != 3'd0) && (o != 3'd7);
    expn   = !acc ? 0 : (o == 3'd1 || o == 3'd2) ? 5 : (o == 3'd3 || o == 3'd4) ? 10 : 0;
    old_hi = mhi;
    old_lo = mlo;
    if (acc) model_apply(o, x, y);

    @(negedge clk);
    bus.start = 1'b1; bus.cancel = cxl; bus.op = o; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 64) begin
      if (n == 0) begin
        check("hold_hi", bus.hi, old_hi);
        check("hold_lo", bus.lo, old_lo);
      end
      // Stray start while busy carries different operands; it must be dropped.
      bus.start = poke && (n == 1);
      bus.op    = 3'd1;
      bus.a     = $urandom;
      bus.b     = $urandom;
      n++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("busy_len", n, expn);
    check("hi", bus.hi, mhi);
    check("lo", bus.lo, mlo);
    bus.rd_hi = 1'b1;
    #1 check("rd_hi", bus.rd_data, mhi);
    bus.rd_hi = 1'b0;
    #1 check("rd_lo", bus.rd_data, mlo);
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] x, y;
    bit          cxl;
    nvec = 0;
    nerr = 0;
    mhi  = '0;
    mlo  = '0;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 3'd0;
    bus.a = '0; bus.b = '0; bus.rd_hi = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_rd", bus.rd_data, 0);
    rst_n = 1'b1;

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0);
    check("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo_const", bus.lo, 32'hFFFF_FFFA);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    check("multu_hi_const", bus.hi, 32'hFFFF_FFFE);
    check("multu_lo_const", bus.lo, 32'h0000_0001);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("div_hi_const", bus.hi, 32'hFFFF_FFFF);
    check("div_lo_const", bus.lo, 32'hFFFF_FFFD);
    run_op(3'd5, 32'h1234, 32'd0, 0, 0);
    run_op(3'd6, 32'h5678, 32'd0, 0, 0);
    run_op(3'd4, 32'd7, 32'd0, 0, 0);
    check("divz_hi_const", bus.hi, 32'h1234);
    check("divz_lo_const", bus.lo, 32'h5678);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("ovf_hi_const", bus.hi, 32'h0);
    check("ovf_lo_const", bus.lo, 32'h8000_0000);
    run_op(3'd0, 32'hDEAD_BEEF, 32'd1, 0, 0);
    run_op(3'd7, 32'hDEAD_BEEF, 32'd1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      o   = 3'($urandom_range(0, 7));
      x   = $urandom;
      y   = $urandom;
      cxl = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 4) == 0) y = 32'd0;
      if ($urandom_range(0, 7) == 0) y = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 9) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      run_op(o, x, y, cxl, $urandom_range(0, 1) == 1);
    end

    run_op(3'd5, 32'hA5A5_0001, 32'd0, 0, 0);
    run_op(3'd6, 32'h5A5A_0002, 32'd0, 0, 0);
    run_op(3'd1, 32'd12345, 32'd678, 1, 0);
    check("cancel_hi", bus.hi, 32'hA5A5_0001);

    // Reset in the middle of a divide: state clears at once and nothing commits later.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_busy", bus.busy, 0);
    check("post_hi", bus.hi, mhi);
    check("post_lo", bus.lo, mlo);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
